// File: rtl/vga_pixel_out.sv
// vga_pixel_out: final VGA stage - realigns sync/enable with late colour, blanks and scales colour, counts frames.
// Optional raster-size checker (err_h/err_v) is built when VGA_PIXEL_OUT_CHECK_EN is defined.
module vga_pixel_out #(
    parameter int PIPE_DLY     = 1,
    parameter int COLOR_W      = 4,
    parameter int SYNC_ACT_LOW = 1,
    parameter int H_DISP       = 640,
    parameter int V_DISP       = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hsync_i,
    input  logic               vsync_i,
    input  logic               disp_en_i,
    input  logic               r_i,
    input  logic               g_i,
    input  logic               b_i,
    input  logic [COLOR_W-1:0] bright_i,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n,
    output logic               frame_start,
    output logic [15:0]        frame_cnt,
    output logic               err_h,
    output logic               err_v
);

    // Inactive level of both sync lines; also their reset value.
    localparam logic SYNC_IDLE = (SYNC_ACT_LOW != 0);

    // Aligned timing signals (same cycle as r_i/g_i/b_i).
    logic hs_a;
    logic vs_a;
    logic en_a;
    // 1 once the aligned slot carries a real sample, not reset fill.
    logic vld_a;
    // vld_a one cycle later, qualifies the previous aligned vsync.
    logic vld_q;
    // Aligned vsync inactive -> active on real samples.
    logic vs_rise;

    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign hs_a  = hsync_i;
            assign vs_a  = vsync_i;
            assign en_a  = disp_en_i;
            assign vld_a = 1'b1;
        end else begin : g_dly
            logic [PIPE_DLY-1:0] hs_sr;
            logic [PIPE_DLY-1:0] vs_sr;
            logic [PIPE_DLY-1:0] en_sr;
            logic [PIPE_DLY-1:0] vld_sr;

            // Delay timing signals so they meet the colour bits; vld marks real samples.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hs_sr  <= {PIPE_DLY{SYNC_IDLE}};
                    vs_sr  <= {PIPE_DLY{SYNC_IDLE}};
                    en_sr  <= '0;
                    vld_sr <= '0;
                end else begin
                    hs_sr[0]  <= hsync_i;
                    vs_sr[0]  <= vsync_i;
                    en_sr[0]  <= disp_en_i;
                    vld_sr[0] <= 1'b1;
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        hs_sr[i]  <= hs_sr[i-1];
                        vs_sr[i]  <= vs_sr[i-1];
                        en_sr[i]  <= en_sr[i-1];
                        vld_sr[i] <= vld_sr[i-1];
                    end
                end
            end

            assign hs_a  = hs_sr[PIPE_DLY-1];
            assign vs_a  = vs_sr[PIPE_DLY-1];
            assign en_a  = en_sr[PIPE_DLY-1];
            assign vld_a = vld_sr[PIPE_DLY-1];
        end
    endgenerate

    // A frame starts when vga_vs is about to show its first active cycle,
    // provided the previous level it held was a real sample.
    assign vs_rise = vld_q
                   & (vs_a != SYNC_IDLE)
                   & (vga_vs == SYNC_IDLE);

    // Output register: pins, blanking and colour expansion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= SYNC_IDLE;
            vga_vs      <= SYNC_IDLE;
            vga_blank_n <= 1'b0;
            vld_q       <= 1'b0;
        end else begin
            vga_r       <= (en_a && r_i) ? bright_i : '0;
            vga_g       <= (en_a && g_i) ? bright_i : '0;
            vga_b       <= (en_a && b_i) ? bright_i : '0;
            vga_hs      <= hs_a;
            vga_vs      <= vs_a;
            vga_blank_n <= en_a;
            vld_q       <= vld_a;
        end
    end

    // Frame-start pulse and wrapping frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_start <= vs_rise;
            if (vs_rise) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

`ifdef VGA_PIXEL_OUT_CHECK_EN
    localparam logic [15:0] H_EXP = 16'(H_DISP);
    localparam logic [15:0] V_EXP = 16'(V_DISP);

    logic [15:0] pix_cnt;
    logic [15:0] line_cnt;
    logic        seen_vs;
    logic        en_fall;
    logic        err_h_q;
    logic        err_v_q;

    // vga_blank_n holds the previous aligned enable.
    assign en_fall = ~en_a & vga_blank_n;

    // Active pixels in the current line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt <= '0;
        end else if (en_a) begin
            pix_cnt <= pix_cnt + 16'd1;
        end else if (en_fall) begin
            pix_cnt <= '0;
        end
    end

    // Active lines since the last vsync; the first vsync only clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt <= '0;
            seen_vs  <= 1'b0;
        end else if (vs_rise) begin
            line_cnt <= '0;
            seen_vs  <= 1'b1;
        end else if (en_fall) begin
            line_cnt <= line_cnt + 16'd1;
        end
    end

    // Sticky size errors, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_h_q <= 1'b0;
            err_v_q <= 1'b0;
        end else begin
            if (en_fall && (pix_cnt != H_EXP)) begin
                err_h_q <= 1'b1;
            end
            if (vs_rise && seen_vs && (line_cnt != V_EXP)) begin
                err_v_q <= 1'b1;
            end
        end
    end

    assign err_h = err_h_q;
    assign err_v = err_v_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{H_DISP, V_DISP};
    assign err_h      = 1'b0;
    assign err_v      = 1'b0;
`endif

endmodule
